// File: rtl/cavlc_pkg.sv
// Purpose: shared types and constants for the CAVLC coefficient builder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: default widths, the builder FSM state type, and the 4x4 zigzag
// table that maps a scan index to a raster (row*4+col) index.
package cavlc_pkg;

    localparam int LEVEL_W_DEFAULT   = 13;
    localparam int MAX_COEFF_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_TZ,
        PLACE,
        DRAIN
    } cb_state_t;

    // Scan index -> raster position for a 4x4 block.
    localparam logic [3:0] ZIGZAG4x4 [16] = '{
        4'd0,  4'd1,  4'd4,  4'd8,
        4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10,
        4'd7,  4'd11, 4'd14, 4'd15
    };

endpackage

// File: rtl/coeff_builder.sv
// Purpose: buffer a block's CAVLC levels, place them using TotalZeros/run_before, stream the full block.
// Latency: level 0 placed 1 cycle after TotalZerosValid; each run-driven level 1 cycle after its RunBeforeValid.
// Backpressure: DRAIN beats advance only on CoeffValid & CoeffReady; CoeffOut/CoeffIdx held otherwise.
//
// Ports: Clk/Reset (async, active-high); Start+TotalCoeff open a block;
// LevelIn/LevelWrReq, TotalZeros/TotalZerosValid, RunBefore/RunBeforeValid
// come from the upstream decoders; CoeffOut/CoeffIdx/CoeffValid/CoeffReady is
// the output stream; BlockDone marks the final accepted beat; Busy is high
// outside IDLE; Err is a sticky per-block protocol/range error flag.
// Build option COEFF_BUILDER_DEZIGZAG_EN: CoeffIdx carries the raster position
// instead of the scan index (ignored for 4-coefficient chroma DC blocks).
module coeff_builder
    import cavlc_pkg::*;
#(
    parameter int MAX_COEFF = MAX_COEFF_DEFAULT,
    parameter int LEVEL_W   = LEVEL_W_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [4:0]         TotalCoeff,
    input  logic [LEVEL_W-1:0] LevelIn,
    input  logic               LevelWrReq,
    input  logic [3:0]         TotalZeros,
    input  logic               TotalZerosValid,
    input  logic [3:0]         RunBefore,
    input  logic               RunBeforeValid,
    output logic [LEVEL_W-1:0] CoeffOut,
    output logic [3:0]         CoeffIdx,
    output logic               CoeffValid,
    input  logic               CoeffReady,
    output logic               BlockDone,
    output logic               Busy,
    output logic               Err
);

    localparam int         IW   = (MAX_COEFF > 1) ? $clog2(MAX_COEFF) : 1;
    localparam logic [4:0] MAXC = 5'(MAX_COEFF);
    localparam logic [4:0] LAST = 5'(MAX_COEFF - 1);

    cb_state_t state, state_nxt;

    logic [4:0]         tc, lvl_cnt, pos, zeros_left, idx, beat;
    logic               wait_run;
    logic [LEVEL_W-1:0] lvl  [MAX_COEFF];
    logic [LEVEL_W-1:0] coef [MAX_COEFF];

    logic [5:0] tz_sum;
    logic       run_over;
    logic [4:0] run_eff;
    logic       last_lvl;
    logic       final_beat;

    assign tz_sum     = {1'b0, tc} + {2'b0, TotalZeros};
    assign run_over   = {1'b0, RunBefore} > zeros_left;
    assign run_eff    = run_over ? zeros_left : {1'b0, RunBefore};
    assign last_lvl   = (idx == tc - 5'd1);
    assign final_beat = (state == DRAIN) && CoeffReady && (beat == LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (Start) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                COLLECT: begin
                    if (tc == 5'd0)
                        state_nxt = DRAIN;
                    else if (LevelWrReq && (lvl_cnt + 5'd1 == tc))
                        state_nxt = WAIT_TZ;
                end
                WAIT_TZ: if (TotalZerosValid) state_nxt = PLACE;
                PLACE:   if (!wait_run && last_lvl) state_nxt = DRAIN;
                DRAIN:   if (final_beat) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tc         <= '0;
            lvl_cnt    <= '0;
            pos        <= '0;
            zeros_left <= '0;
            idx        <= '0;
            beat       <= '0;
            wait_run   <= 1'b0;
            Err        <= 1'b0;
            for (int i = 0; i < MAX_COEFF; i++) begin
                lvl[i]  <= '0;
                coef[i] <= '0;
            end
        end else if (Start) begin
            // An out-of-range count is clamped so every later index stays in bounds.
            tc       <= (TotalCoeff > MAXC) ? MAXC : TotalCoeff;
            Err      <= (TotalCoeff > MAXC);
            lvl_cnt  <= '0;
            idx      <= '0;
            beat     <= '0;
            wait_run <= 1'b0;
            for (int i = 0; i < MAX_COEFF; i++) begin
                lvl[i]  <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (LevelWrReq) begin
                if (state == COLLECT && lvl_cnt < tc) begin
                    lvl[lvl_cnt[IW-1:0]] <= LevelIn;
                    lvl_cnt              <= lvl_cnt + 5'd1;
                end else begin
                    Err <= 1'b1;
                end
            end

            if (TotalZerosValid) begin
                if (state == WAIT_TZ) begin
                    idx <= '0;
                    if (tz_sum > {1'b0, MAXC}) begin
                        // Keep Pos == remaining levels + ZerosLeft so runs cannot underflow Pos.
                        Err        <= 1'b1;
                        pos        <= LAST;
                        zeros_left <= MAXC - tc;
                    end else begin
                        pos        <= tc - 5'd1 + {1'b0, TotalZeros};
                        zeros_left <= {1'b0, TotalZeros};
                    end
                end else begin
                    Err <= 1'b1;
                end
            end

            if (RunBeforeValid) begin
                if (state == PLACE && wait_run) begin
                    if (run_over) Err <= 1'b1;
                    pos        <= pos - run_eff - 5'd1;
                    zeros_left <= zeros_left - run_eff;
                    wait_run   <= 1'b0;
                end else begin
                    Err <= 1'b1;
                end
            end

            // Write phase of PLACE; a following run (if any zeros remain) pauses placement.
            if (state == PLACE && !wait_run) begin
                coef[pos[IW-1:0]] <= lvl[idx[IW-1:0]];
                if (!last_lvl) begin
                    idx <= idx + 5'd1;
                    if (zeros_left != 5'd0) wait_run <= 1'b1;
                    else                    pos      <= pos - 5'd1;
                end
            end

            if (state == DRAIN && CoeffReady) begin
                if (beat == LAST) begin
                    beat <= '0;
                    for (int i = 0; i < MAX_COEFF; i++) begin
                        lvl[i]  <= '0;
                        coef[i] <= '0;
                    end
                end else begin
                    beat <= beat + 5'd1;
                end
            end
        end
    end

    always_comb begin
        CoeffValid = 1'b0;
        CoeffOut   = '0;
        CoeffIdx   = '0;
        BlockDone  = final_beat;
        Busy       = (state != IDLE);
        if (state == DRAIN) begin
            CoeffValid = 1'b1;
            CoeffOut   = coef[beat[IW-1:0]];
`ifdef COEFF_BUILDER_DEZIGZAG_EN
            CoeffIdx   = (MAX_COEFF == 4) ? 4'(beat) : ZIGZAG4x4[beat[3:0]];
`else
            CoeffIdx   = 4'(beat);
`endif
        end
    end

endmodule

// File: tb/tb_coeff_builder.sv
// Purpose: directed self-checking bench for coeff_builder.
// Latency: checks placement latency and drain timing with bounded waits.
// Backpressure: drains with CoeffReady steady or toggled, checking beats hold while stalled.
module tb_coeff_builder;

    localparam int LW = 13;
    localparam int MC = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [4:0]    TotalCoeff;
    logic [LW-1:0] LevelIn;
    logic          LevelWrReq;
    logic [3:0]    TotalZeros;
    logic          TotalZerosValid;
    logic [3:0]    RunBefore;
    logic          RunBeforeValid;
    logic [LW-1:0] CoeffOut;
    logic [3:0]    CoeffIdx;
    logic          CoeffValid;
    logic          CoeffReady;
    logic          BlockDone;
    logic          Busy;
    logic          Err;

    coeff_builder dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .TotalCoeff(TotalCoeff),
        .LevelIn(LevelIn), .LevelWrReq(LevelWrReq),
        .TotalZeros(TotalZeros), .TotalZerosValid(TotalZerosValid),
        .RunBefore(RunBefore), .RunBeforeValid(RunBeforeValid),
        .CoeffOut(CoeffOut), .CoeffIdx(CoeffIdx), .CoeffValid(CoeffValid),
        .CoeffReady(CoeffReady), .BlockDone(BlockDone), .Busy(Busy), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [LW-1:0] exp_val [MC];
    logic [LW-1:0] got_val [MC];
    logic [3:0]    got_idx [MC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_idx(input int i);
`ifdef COEFF_BUILDER_DEZIGZAG_EN
        case (i)
            0: return 4'd0;   1: return 4'd1;   2: return 4'd4;   3: return 4'd8;
            4: return 4'd5;   5: return 4'd2;   6: return 4'd3;   7: return 4'd6;
            8: return 4'd9;   9: return 4'd12;  10: return 4'd13; 11: return 4'd10;
            12: return 4'd7;  13: return 4'd11; 14: return 4'd14; default: return 4'd15;
        endcase
`else
        return 4'(i);
`endif
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < MC; i++) exp_val[i] = '0;
    endtask

    task automatic start_block(input logic [4:0] tc);
        Start = 1'b1; TotalCoeff = tc;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_level(input logic [LW-1:0] v);
        LevelWrReq = 1'b1; LevelIn = v;
        tick();
        LevelWrReq = 1'b0;
    endtask

    task automatic send_tz(input logic [3:0] z);
        TotalZerosValid = 1'b1; TotalZeros = z;
        tick();
        TotalZerosValid = 1'b0;
    endtask

    // One idle cycle first so the run arrives while the builder waits for it.
    task automatic send_run(input logic [3:0] r);
        tick();
        RunBeforeValid = 1'b1; RunBefore = r;
        tick();
        RunBeforeValid = 1'b0;
    endtask

    task automatic drain(input string tag, input bit toggle);
        int            got_n    = 0;
        int            done_n   = 0;
        int            hold_bad = 0;
        bit            done_last = 1'b0;
        bit            prev_hold = 1'b0;
        logic [LW-1:0] prev_out = '0;
        logic [3:0]    prev_idx = '0;
        for (int cyc = 0; cyc < 300 && got_n < MC; cyc++) begin
            CoeffReady = toggle ? ((cyc % 2) == 1) : 1'b1;
            #1;
            if (prev_hold && (!CoeffValid || CoeffOut !== prev_out || CoeffIdx !== prev_idx))
                hold_bad++;
            if (BlockDone) begin
                done_n++;
                if (got_n == MC - 1) done_last = 1'b1;
            end
            prev_hold = CoeffValid && !CoeffReady;
            prev_out  = CoeffOut;
            prev_idx  = CoeffIdx;
            if (CoeffValid && CoeffReady) begin
                got_val[got_n] = CoeffOut;
                got_idx[got_n] = CoeffIdx;
                got_n++;
            end
            if (got_n < MC) tick();
        end
        tick();
        CoeffReady = 1'b0;
        chk({tag, "_beats"}, 32'(got_n), 32'(MC));
        chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
        chk({tag, "_done_last"}, {31'd0, done_last}, 32'd1);
        chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
        for (int i = 0; i < MC && i < got_n; i++) begin
            chk($sformatf("%s_v%0d", tag, i), 32'(got_val[i]), 32'(exp_val[i]));
            chk($sformatf("%s_i%0d", tag, i), 32'(got_idx[i]), 32'(exp_idx(i)));
        end
        chk({tag, "_busy_after"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0; TotalCoeff = '0; LevelIn = '0; LevelWrReq = 1'b0;
        TotalZeros = '0; TotalZerosValid = 1'b0; RunBefore = '0; RunBeforeValid = 1'b0;
        CoeffReady = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_valid", {31'd0, CoeffValid}, 32'd0);
        chk("rst_err", {31'd0, Err}, 32'd0);
        chk("rst_out", 32'(CoeffOut), 32'd0);
        chk("rst_done", {31'd0, BlockDone}, 32'd0);
        Reset = 1'b0;
        tick();

        // Example block: TC=5, levels 1,1,-1,-1,3, TZ=4, runs 1,0,2,0.
        clear_exp();
        exp_val[1] = 13'd3; exp_val[2] = -13'sd1; exp_val[5] = -13'sd1;
        exp_val[6] = 13'd1; exp_val[8] = 13'd1;
        start_block(5'd5);
        send_level(13'd1); send_level(13'd1); send_level(-13'sd1); send_level(-13'sd1);
        send_level(13'd3);
        send_tz(4'd4);
        send_run(4'd1); send_run(4'd0); send_run(4'd2); send_run(4'd0);
        drain("ex", 1'b0);
        chk("ex_err", {31'd0, Err}, 32'd0);

        // TC=3, TZ=0: no runs, DRAIN 4 cycles after TotalZerosValid.
        clear_exp();
        exp_val[0] = 13'd7; exp_val[1] = 13'd6; exp_val[2] = 13'd5;
        start_block(5'd3);
        send_level(13'd5); send_level(13'd6); send_level(13'd7);
        send_tz(4'd0);
        n = 1;
        while (!CoeffValid && n < 20) begin
            tick();
            n++;
        end
        chk("tz0_latency", 32'(n), 32'd4);
        drain("tz0", 1'b0);

        // TC=0 with toggling ready: 16 zero beats, none lost or duplicated.
        clear_exp();
        start_block(5'd0);
        drain("tc0", 1'b1);
        chk("tc0_err", {31'd0, Err}, 32'd0);

        // Unexpected run in IDLE sets Err; Start clears it.
        RunBeforeValid = 1'b1; RunBefore = 4'd2;
        tick();
        RunBeforeValid = 1'b0;
        chk("stray_run_err", {31'd0, Err}, 32'd1);
        start_block(5'd0);
        chk("start_clr_err", {31'd0, Err}, 32'd0);
        clear_exp();
        drain("tc0b", 1'b0);

        // Stray TotalZerosValid in IDLE sets Err.
        send_tz(4'd3);
        chk("stray_tz_err", {31'd0, Err}, 32'd1);

        // Abort during PLACE, then TC=1, level -2, TZ=15 -> only idx15=-2.
        start_block(5'd3);
        send_level(13'd5); send_level(13'd6); send_level(13'd7);
        send_tz(4'd0);
        clear_exp();
        exp_val[15] = -13'sd2;
        start_block(5'd1);
        send_level(-13'sd2);
        send_tz(4'd15);
        drain("abort", 1'b0);
        chk("abort_err", {31'd0, Err}, 32'd0);

        // TC=2, TZ=14: sum 16 is legal.
        clear_exp();
        exp_val[15] = 13'd1; exp_val[0] = 13'd2;
        start_block(5'd2);
        send_level(13'd1); send_level(13'd2);
        send_tz(4'd14);
        send_run(4'd14);
        drain("sum16", 1'b0);
        chk("sum16_err", {31'd0, Err}, 32'd0);

        // TC=2, TZ=15: over range, Err set, first level pinned to the last position.
        clear_exp();
        exp_val[15] = 13'd4; exp_val[14] = 13'd5;
        start_block(5'd2);
        send_level(13'd4); send_level(13'd5);
        send_tz(4'd15);
        send_run(4'd0);
        drain("sum17", 1'b0);
        chk("sum17_err", {31'd0, Err}, 32'd1);

        // Run 3 with ZerosLeft=1: Err, run clamped to 1.
        clear_exp();
        exp_val[2] = 13'd3; exp_val[0] = -13'sd3;
        start_block(5'd2);
        send_level(13'd3); send_level(-13'sd3);
        send_tz(4'd1);
        send_run(4'd3);
        drain("clamp", 1'b0);
        chk("clamp_err", {31'd0, Err}, 32'd1);

        // Reset in mid-DRAIN: outputs drop at once.
        start_block(5'd1);
        send_level(13'd9);
        send_tz(4'd2);
        for (int k = 0; k < 20 && !CoeffValid; k++) tick();
        chk("mid_valid", {31'd0, CoeffValid}, 32'd1);
        CoeffReady = 1'b1;
        tick(); tick();
        CoeffReady = 1'b0;
        chk("mid_out", 32'(CoeffOut), 32'd9);
        send_level(13'd5);
        chk("mid_stray_lvl_err", {31'd0, Err}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, CoeffValid}, 32'd0);
        chk("mrst_out", 32'(CoeffOut), 32'd0);
        chk("mrst_idx", 32'(CoeffIdx), 32'd0);
        chk("mrst_busy", {31'd0, Busy}, 32'd0);
        chk("mrst_err", {31'd0, Err}, 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_busy", {31'd0, Busy}, 32'd0);
        chk("post_valid", {31'd0, CoeffValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
